// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/memory-stage RAM port arbiter.
// State and owner enums used by the arbiter top and its bench.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_RUN   = 2'd0,
    ARB_LOAD  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  localparam int ARB_DATA_W_DEF     = 32;
  localparam int ARB_ADDR_W_DEF     = 7;
  localparam int ARB_STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating fetch-denial counter: clear wins over increment, holds at MAX.
// Registered output, no backpressure.
module arb_starve_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between fetch (read) and memory stage (read/write), grants combinational.
// Read data returns one cycle after grant; losers see no grant and must hold their request.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = ARB_DATA_W_DEF,
  parameter int ADDR_W     = ARB_ADDR_W_DEF,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ram_load,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              fetch_stall,
  input  logic              mem_req,
  input  logic              mem_wre,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wre,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  owner_e            owner;
  owner_e            rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic [SW-1:0]     starve_cnt;
  logic              grant_ok;
  logic              fetch_first;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN:   if (ram_load)  state_d = ARB_LOAD;
      ARB_LOAD:  if (!ram_load) state_d = ARB_DRAIN;
      ARB_DRAIN: state_d = ARB_RUN;
      default:   state_d = ARB_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset is folded in so nothing is granted while reset is held.
  assign grant_ok    = reset && (state_q == ARB_RUN) && !ram_load;
  assign fetch_first = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    owner = OWN_NONE;
    if (grant_ok) begin
      if (if_req && (!mem_req || fetch_first)) begin
        owner = OWN_IF;
      end else if (mem_req) begin
        owner = OWN_MEM;
      end
    end
  end

  assign if_gnt      = (owner == OWN_IF);
  assign mem_gnt     = (owner == OWN_MEM);
  assign fetch_stall = if_req && !if_gnt;

  always_comb begin
    ram_addr = '0;
    if (if_gnt) begin
      ram_addr = if_addr;
    end else if (mem_gnt) begin
      ram_addr = mem_addr;
    end
  end

  assign ram_wre   = mem_gnt && mem_wre;
  assign ram_wdata = mem_wdata;

  arb_starve_counter #(
    .MAX (STARVE_MAX),
    .W   (SW)
  ) u_starve (
    .clock (clock),
    .reset (reset),
    .clr_i (if_gnt),
    .inc_i (fetch_stall),
    .cnt_o (starve_cnt)
  );

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (if_gnt) begin
      rd_owner_d = OWN_IF;
    end else if (mem_gnt && !mem_wre) begin
      rd_owner_d = OWN_MEM;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_owner_q  <= OWN_NONE;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (if_rvalid)  if_rdata_q  <= ram_rdata;
      if (mem_rvalid) mem_rdata_q <= ram_rdata;
    end
  end

  assign if_rvalid  = (rd_owner_q == OWN_IF);
  assign mem_rvalid = (rd_owner_q == OWN_MEM);

  // RAM data is live in the return cycle; the register keeps it afterwards.
  assign if_rdata  = if_rvalid  ? ram_rdata : if_rdata_q;
  assign mem_rdata = mem_rvalid ? ram_rdata : mem_rdata_q;

endmodule
